// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD controller DAT paths.
//   sd_rx_state_e   - receive deserialiser FSM states
//   sd_rx_status_t  - done/crc_err/timeout flags reported to the command FSM
//   SD_CRC16_*      - CRC16-CCITT polynomial and seed
//   sd_crc16_step   - one serial CRC16 step, MSB-first
package sd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      DATA,
      CRC,
      END_BIT
   } sd_rx_state_e;

   typedef struct packed {
      logic done;
      logic crc_err;
      logic timeout;
   } sd_rx_status_t;

   localparam logic [15:0] SD_CRC16_POLY = 16'h1021;
   localparam logic [15:0] SD_CRC16_INIT = 16'h0000;

   // Feedback is the incoming bit XOR the current MSB; shift, then fold in the polynomial.
   function automatic logic [15:0] sd_crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[15];
      return {crc[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// sd_crc16_serial: bit-serial CRC16-CCITT accumulator, shared by the RX and TX DAT paths.
//   clk  in   system clock
//   rst  in   synchronous active-high reset (crc -> seed)
//   clr  in   reload seed (takes priority over en)
//   en   in   advance the CRC by one bit
//   din  in   serial data bit
//   crc  out  current CRC value
module sd_crc16_serial
   import sd_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr)     crc_d = SD_CRC16_INIT;
      else if (en) crc_d = sd_crc16_step(crc_q, din);
   end

   always_ff @(posedge clk) begin
      if (rst) crc_q <= SD_CRC16_INIT;
      else     crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_dat_rx_deser.sv
// sd_dat_rx_deser: SD DAT0 receive deserialiser (1-bit bus mode).
//   Waits for a start bit, shifts in a DATA_BITS block MSB-first, writes it to the
//   regfile as two HALF_BITS halves (lower first), then checks CRC16 and the end bit.
//   clk, rst         clock, synchronous active-high reset
//   start            arm the receiver (only honoured in IDLE)
//   bit_stb          one-cycle bit strobe; sd_dat0 is sampled only when high
//   sd_dat0          synchronised DAT0 line
//   rf_rw            one-cycle regfile write pulse per half
//   rf_sel           regfile half select (0 lower, 1 upper), holds last value
//   rf_data          completed half, held until the next write
//   busy             high whenever not IDLE
//   done             one-cycle end-of-block / timeout pulse
//   crc_err, timeout status flags, only non-zero alongside done
module sd_dat_rx_deser
   import sd_pkg::*;
#(
   parameter int DATA_BITS = 1024,
   parameter int HALF_BITS = 512,
   parameter int TIMEOUT   = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 bit_stb,
   input  logic                 sd_dat0,
   output logic                 rf_rw,
   output logic                 rf_sel,
   output logic [HALF_BITS-1:0] rf_data,
   output logic                 busy,
   output logic                 done,
   output logic                 crc_err,
   output logic                 timeout
);

   localparam int CNT_W = $clog2(DATA_BITS);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_CRC  = CNT_W'(15);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   sd_rx_state_e         state_q,   state_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [TO_W-1:0]      to_cnt_q,  to_cnt_d;
   logic [HALF_BITS-1:0] shift_q,   shift_d;
   logic [15:0]          rx_crc_q,  rx_crc_d;
   logic                 rf_rw_q,   rf_rw_d;
   logic                 rf_sel_q,  rf_sel_d;
   logic [HALF_BITS-1:0] rf_data_q, rf_data_d;
   sd_rx_status_t        stat_q,    stat_d;

   logic [HALF_BITS-1:0] shift_in;
   logic [15:0]          crc_val;
   logic                 crc_clr;
   logic                 crc_en;

   // Shift register with the strobed bit appended at the LSB.
   assign shift_in = (shift_q << 1) | HALF_BITS'(sd_dat0);

   // CRC is seeded when armed and only sees payload bits.
   assign crc_clr = (state_q == IDLE) && start;
   assign crc_en  = (state_q == DATA) && bit_stb;

   sd_crc16_serial u_crc (
      .clk (clk),
      .rst (rst),
      .clr (crc_clr),
      .en  (crc_en),
      .din (sd_dat0),
      .crc (crc_val)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      to_cnt_d  = to_cnt_q;
      shift_d   = shift_q;
      rx_crc_d  = rx_crc_q;
      rf_rw_d   = 1'b0;
      rf_sel_d  = rf_sel_q;
      rf_data_d = rf_data_q;
      stat_d    = '0;

      unique case (state_q)
         IDLE: begin
            // A strobe coincident with start is deliberately not sampled.
            if (start) begin
               state_d   = WAIT_START;
               to_cnt_d  = '0;
               bit_cnt_d = '0;
            end
         end
         WAIT_START: begin
            if (bit_stb) begin
               if (!sd_dat0) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end else if (to_cnt_q == TO_LAST) begin
                  state_d        = IDLE;
                  stat_d.done    = 1'b1;
                  stat_d.timeout = 1'b1;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (bit_stb) begin
               shift_d   = shift_in;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CNT_HALF) begin
                  rf_rw_d   = 1'b1;
                  rf_sel_d  = 1'b0;
                  rf_data_d = shift_in;
               end
               if (bit_cnt_q == CNT_LAST) begin
                  rf_rw_d   = 1'b1;
                  rf_sel_d  = 1'b1;
                  rf_data_d = shift_in;
                  bit_cnt_d = '0;
                  state_d   = CRC;
               end
            end
         end
         CRC: begin
            // Bit counter is reused to count the 16 received CRC bits.
            if (bit_stb) begin
               rx_crc_d  = {rx_crc_q[14:0], sd_dat0};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CNT_CRC) state_d = END_BIT;
            end
         end
         END_BIT: begin
            if (bit_stb) begin
               state_d        = IDLE;
               stat_d.done    = 1'b1;
               stat_d.crc_err = (rx_crc_q != crc_val) | ~sd_dat0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         to_cnt_q  <= '0;
         shift_q   <= '0;
         rx_crc_q  <= '0;
         rf_rw_q   <= 1'b0;
         rf_sel_q  <= 1'b0;
         rf_data_q <= '0;
         stat_q    <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         to_cnt_q  <= to_cnt_d;
         shift_q   <= shift_d;
         rx_crc_q  <= rx_crc_d;
         rf_rw_q   <= rf_rw_d;
         rf_sel_q  <= rf_sel_d;
         rf_data_q <= rf_data_d;
         stat_q    <= stat_d;
      end
   end

   assign rf_rw   = rf_rw_q;
   assign rf_sel  = rf_sel_q;
   assign rf_data = rf_data_q;
   assign busy    = (state_q != IDLE);
   assign done    = stat_q.done;
   assign crc_err = stat_q.crc_err;
   assign timeout = stat_q.timeout;

endmodule

// File: tb/tb_sd_dat_rx_deser.sv
// Bench for sd_dat_rx_deser: frames are built from a 1024-bit block, a CRC word and an
// end bit; the expected regfile writes and status pulses are derived from the frame
// itself and checked every cycle by a single compare process.
module tb_sd_dat_rx_deser;

   logic         clk = 1'b0;
   logic         rst, start, bit_stb, sd_dat0;
   logic         rf_rw, rf_sel, busy, done, crc_err, timeout;
   logic [511:0] rf_data;

   int n_cmp = 0;
   int n_bad = 0;

   // Expected outputs after the next active edge.
   logic         chk_en = 1'b0;
   logic         e_rw, e_sel, e_done, e_ce, e_to, e_busy;
   logic [511:0] e_data;

   sd_dat_rx_deser dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bit_stb (bit_stb),
      .sd_dat0 (sd_dat0),
      .rf_rw   (rf_rw),
      .rf_sel  (rf_sel),
      .rf_data (rf_data),
      .busy    (busy),
      .done    (done),
      .crc_err (crc_err),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic cmp1(input string nm, input logic a, input logic e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
      end
   endtask

   task automatic cmp16(input string nm, input logic [15:0] a, input logic [15:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic cmpd(input string nm, input logic [511:0] a, input logic [511:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
      end
   endtask

   // Single compare process, sampling 1 time unit after each edge.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         cmp1("rf_rw",   rf_rw,   e_rw);
         cmp1("rf_sel",  rf_sel,  e_sel);
         cmpd("rf_data", rf_data, e_data);
         cmp1("busy",    busy,    e_busy);
         cmp1("done",    done,    e_done);
         cmp1("crc_err", crc_err, e_ce);
         cmp1("timeout", timeout, e_to);
      end
   end

   // Reference CRC16-CCITT (0x1021, seed 0) over v[n-1] down to v[0].
   function automatic logic [15:0] model_crc(input logic [1023:0] v, input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'h0000;
      for (int i = n - 1; i >= 0; i--) begin
         fb = v[i] ^ c[15];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   // Apply inputs for one cycle; pulse expectations clear once the edge is checked.
   task automatic tick(input logic s, input logic st, input logic d, input logic r);
      start = s; bit_stb = st; sd_dat0 = d; rst = r;
      @(posedge clk);
      #2;
      e_rw = 1'b0; e_done = 1'b0; e_ce = 1'b0; e_to = 1'b0;
   endtask

   // Non-strobe cycles with junk on DAT0 and start noise while busy.
   task automatic gap();
      repeat ($urandom_range(0, 2))
         tick(e_busy && ($urandom_range(0, 7) == 0), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic sb(input logic d, input logic w, input logic ws, input logic [511:0] wd,
                     input logic dn, input logic ce, input logic to);
      gap();
      e_rw = w;
      if (w) begin
         e_sel  = ws;
         e_data = wd;
      end
      e_done = dn; e_ce = ce; e_to = to;
      if (dn) e_busy = 1'b0;
      tick(e_busy && ($urandom_range(0, 7) == 0), 1'b1, d, 1'b0);
   endtask

   // Arm; a coincident strobe carrying a 0 must not count as the start bit.
   task automatic arm();
      gap();
      e_busy = 1'b1;
      tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
   endtask

   task automatic send_frame(input logic [1023:0] blk, input logic [15:0] crc_tx,
                             input logic endb, input int pre_ones, input int abort_at);
      arm();
      repeat (pre_ones) sb(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      sb(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 1024; i++) begin
         if (i == abort_at) begin
            gap();
            e_busy = 1'b0; e_sel = 1'b0; e_data = '0;
            tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
            return;
         end
         sb(blk[1023 - i], (i == 511) || (i == 1023), (i == 1023),
            (i == 511) ? blk[1023:512] : blk[511:0], 1'b0, 1'b0, 1'b0);
      end
      for (int i = 15; i >= 0; i--) sb(crc_tx[i], 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      sb(endb, 1'b0, 1'b0, '0, 1'b1, (crc_tx != model_crc(blk, 1024)) || !endb, 1'b0);
   endtask

   task automatic rand_blk(output logic [1023:0] b);
      for (int w = 0; w < 32; w++) b[w*32 +: 32] = $urandom();
   endtask

   initial begin
      logic [1023:0] blk, v;
      logic [511:0]  lo, hi;
      logic [15:0]   c;

      rst = 1'b1; start = 1'b0; bit_stb = 1'b0; sd_dat0 = 1'b1;
      e_rw = 1'b0; e_sel = 1'b0; e_data = '0; e_busy = 1'b0;
      e_done = 1'b0; e_ce = 1'b0; e_to = 1'b0;
      chk_en = 1'b1;

      // Pin the reference CRC against known values.
      v = '0; v[71:0] = "123456789";
      cmp16("model_crc_123456789", model_crc(v, 72), 16'h31C3);
      v = '0; v[0] = 1'b1;
      cmp16("model_crc_last_one", model_crc(v, 1024), 16'h1021);
      v = '0;
      cmp16("model_crc_zero", model_crc(v, 1024), 16'h0000);

      tick(1'b0, 1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0);

      // All-zero block, clean.
      send_frame('0, 16'h0000, 1'b1, 0, -1);

      // Pattern block.
      lo  = {{16{16'hAAAA}}, {16{16'hCCCC}}};
      hi  = {{16{16'hFFFF}}, {16{16'h0000}}};
      blk = {lo, hi};
      send_frame(blk, model_crc(blk, 1024), 1'b1, 3, -1);

      // Bad CRC on all-zero data.
      send_frame('0, 16'h0001, 1'b1, 0, -1);

      // Good CRC, bad end bit.
      rand_blk(blk);
      send_frame(blk, model_crc(blk, 1024), 1'b0, 1, -1);

      // Timeout: no start bit in 4096 strobes.
      arm();
      for (int k = 1; k <= 4096; k++)
         sb(1'b1, 1'b0, 1'b0, '0, (k == 4096), 1'b0, (k == 4096));
      repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);

      // Reset mid-block, then a clean block.
      rand_blk(blk);
      send_frame(blk, model_crc(blk, 1024), 1'b1, 2, 300);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
      send_frame('0, 16'h0000, 1'b1, 0, -1);

      // Random blocks, CRC sometimes corrupted.
      repeat (3) begin
         rand_blk(blk);
         c = model_crc(blk, 1024);
         if ($urandom_range(0, 1) == 1) c = c ^ 16'(1 << $urandom_range(0, 15));
         send_frame(blk, c, 1'b1, $urandom_range(0, 20), -1);
      end

      repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
